// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// Holds the read-mode enum, the pointer wrap rule and the count-width helper.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD,
        FIFO_FWFT
    } fifo_mode_e;

    // Depth need not be a power of two, so the wrap is an explicit compare.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

    // Occupancy must be able to represent DEPTH itself, hence DEPTH+1 states.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port; no reset.
// Zero-cycle read latency; no backpressure (the owner decides when to write).
module fifo_ram #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with count, almost-flags, sticky errors and flush.
// STD: q one cycle after rd; FWFT: head word on q. Writes while full drop unless a read pops.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH  = 128,
    parameter int         DEPTH       = 8,
    parameter int         ALMOST_MTY  = 1,
    parameter int         ALMOST_FULL = 1,
    parameter fifo_mode_e MODE        = FIFO_STD
) (
    input  logic                         clk,
    input  logic                         srst_n,
    input  logic                         wr,
    input  logic [DATA_WIDTH-1:0]        data,
    input  logic                         rd,
    input  logic                         flush,
    output logic [DATA_WIDTH-1:0]        q,
    output logic                         q_valid,
    output logic                         full,
    output logic                         almost_full,
    output logic                         mty,
    output logic                         almost_mty,
    output logic [count_w(DEPTH)-1:0]    count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);

    if (DEPTH < 2) begin : g_chk_depth
        $error("fifo_sync_param: DEPTH must be >= 2");
    end
    if (ALMOST_MTY >= DEPTH) begin : g_chk_amty
        $error("fifo_sync_param: ALMOST_MTY must be < DEPTH");
    end
    if (ALMOST_FULL >= DEPTH) begin : g_chk_afull
        $error("fifo_sync_param: ALMOST_FULL must be < DEPTH");
    end

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_next;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rd_acc;
    logic                  wr_acc;

    assign rd_acc = rd & ~mty;
    assign wr_acc = wr & (~full | rd_acc);

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    // Flags come from count_next so they are exact the cycle after any update.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            mty         <= 1'b1;
            almost_mty  <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            count       <= count_next;
            mty         <= (count_next == '0);
            almost_mty  <= (count_next <= CW'(ALMOST_MTY));
            full        <= (count_next == CW'(DEPTH));
            almost_full <= (count_next >= CW'(DEPTH - ALMOST_FULL));
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (wr_acc) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
                if (rd_acc) rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
                if (wr && !wr_acc) overflow  <= 1'b1;
                if (rd && mty)     underflow <= 1'b1;
            end
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc & srst_n & ~flush),
        .waddr (wr_ptr),
        .wdata (data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    if (MODE == FIFO_STD) begin : g_std
        always_ff @(posedge clk) begin
            if (!srst_n) begin
                q       <= '0;
                q_valid <= 1'b0;
            end else if (flush) begin
                q_valid <= 1'b0;
            end else begin
                q_valid <= rd_acc;
                if (rd_acc) q <= rdata;
            end
        end
    end else begin : g_fwft
        assign q       = rdata;
        assign q_valid = ~mty;
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a DEPTH=6 STD instance checked against a scoreboard,
// plus a DEPTH=4 FWFT instance driven with directed steps.
module tb_fifo_sync_param;
    import fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // STD instance signals
    logic       s_srst_n, s_wr, s_rd, s_flush;
    logic [7:0] s_data, s_q;
    logic       s_q_valid, s_full, s_almost_full, s_mty, s_almost_mty, s_overflow, s_underflow;
    logic [2:0] s_count;

    // FWFT instance signals
    logic       f_srst_n, f_wr, f_rd, f_flush;
    logic [7:0] f_data, f_q;
    logic       f_q_valid, f_full, f_almost_full, f_mty, f_almost_mty, f_overflow, f_underflow;
    logic [2:0] f_count;

    fifo_sync_param #(
        .DATA_WIDTH (8), .DEPTH (6), .ALMOST_MTY (1), .ALMOST_FULL (1), .MODE (FIFO_STD)
    ) u_std (
        .clk (clk), .srst_n (s_srst_n), .wr (s_wr), .data (s_data), .rd (s_rd), .flush (s_flush),
        .q (s_q), .q_valid (s_q_valid), .full (s_full), .almost_full (s_almost_full),
        .mty (s_mty), .almost_mty (s_almost_mty), .count (s_count),
        .overflow (s_overflow), .underflow (s_underflow)
    );

    fifo_sync_param #(
        .DATA_WIDTH (8), .DEPTH (4), .ALMOST_MTY (1), .ALMOST_FULL (1), .MODE (FIFO_FWFT)
    ) u_fwft (
        .clk (clk), .srst_n (f_srst_n), .wr (f_wr), .data (f_data), .rd (f_rd), .flush (f_flush),
        .q (f_q), .q_valid (f_q_valid), .full (f_full), .almost_full (f_almost_full),
        .mty (f_mty), .almost_mty (f_almost_mty), .count (f_count),
        .overflow (f_overflow), .underflow (f_underflow)
    );

    // Scoreboard for the STD instance: accepted writes queue here, reads pop them.
    logic [7:0] sb [$];
    logic [7:0] m_last;
    logic       m_ovf, m_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_s(input logic w, input logic [7:0] d, input logic r,
                          input logic f, input logic rst_n);
        int   n;
        logic rd_ok, wr_ok;
        s_wr = w; s_data = d; s_rd = r; s_flush = f; s_srst_n = rst_n;
        n     = sb.size();
        rd_ok = r && (n > 0);
        wr_ok = w && ((n < 6) || rd_ok);
        if (!rst_n) begin
            sb.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_last = 8'h00; rd_ok = 1'b0;
        end else if (f) begin
            sb.delete(); m_ovf = 1'b0; m_unf = 1'b0; rd_ok = 1'b0;
        end else begin
            if (w && !wr_ok) m_ovf = 1'b1;
            if (r && n == 0) m_unf = 1'b1;
            if (wr_ok) sb.push_back(d);
        end
        @(posedge clk); #1;
        s_wr = 1'b0; s_rd = 1'b0; s_flush = 1'b0; s_srst_n = 1'b1;
        if (rd_ok) m_last = sb.pop_front();
        n = sb.size();
        check("std_q_valid",     s_q_valid,     rd_ok);
        check("std_q",           s_q,           m_last);
        check("std_count",       s_count,       n);
        check("std_mty",         s_mty,         n == 0);
        check("std_almost_mty",  s_almost_mty,  n <= 1);
        check("std_full",        s_full,        n == 6);
        check("std_almost_full", s_almost_full, n >= 5);
        check("std_overflow",    s_overflow,    m_ovf);
        check("std_underflow",   s_underflow,   m_unf);
    endtask

    task automatic step_f(input logic w, input logic [7:0] d, input logic r, input logic f);
        f_wr = w; f_data = d; f_rd = r; f_flush = f;
        @(posedge clk); #1;
        f_wr = 1'b0; f_rd = 1'b0; f_flush = 1'b0;
    endtask

    initial begin
        s_srst_n = 1'b0; s_wr = 1'b0; s_rd = 1'b0; s_flush = 1'b0; s_data = 8'h00;
        f_srst_n = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_flush = 1'b0; f_data = 8'h00;
        m_last = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset both instances together.
        step_s(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        f_srst_n = 1'b1;
        check("fwft_rst_mty",     f_mty,     1'b1);
        check("fwft_rst_q_valid", f_q_valid, 1'b0);
        check("fwft_rst_count",   f_count,   3'd0);

        // Fill to full, then one write too many.
        for (int i = 0; i < 6; i++) step_s(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b1);
        step_s(1'b1, 8'h17, 1'b0, 1'b0, 1'b1);
        check("t1_ovf", s_overflow, 1'b1);
        check("t1_count", s_count, 3'd6);

        // Drain, then one read too many.
        for (int i = 0; i < 7; i++) step_s(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("t2_q_hold", s_q, 8'h16);
        check("t2_unf", s_underflow, 1'b1);

        // Pointer wrap on a non-power-of-two depth.
        for (int i = 0; i < 4; i++) step_s(1'b1, 8'h01 + 8'(i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step_s(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step_s(1'b1, 8'h05 + 8'(i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step_s(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("t3_last", s_q, 8'h0A);

        // Simultaneous write and read, when full and when empty.
        step_s(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step_s(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b1);
        step_s(1'b1, 8'h26, 1'b1, 1'b0, 1'b1);
        check("t4_full_ovf", s_overflow, 1'b0);
        for (int i = 0; i < 6; i++) step_s(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("t4_passthru", s_q, 8'h26);
        step_s(1'b1, 8'h27, 1'b1, 1'b0, 1'b1);
        check("t4_empty_unf", s_underflow, 1'b1);
        step_s(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Flush mid-operation with a write in the same cycle.
        step_s(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step_s(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b1);
        step_s(1'b1, 8'h36, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step_s(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step_s(1'b1, 8'h37, 1'b0, 1'b1, 1'b1);
        check("t6_flush_q_hold", s_q, 8'h32);
        step_s(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Same again with reset instead of flush.
        for (int i = 0; i < 6; i++) step_s(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b1);
        step_s(1'b1, 8'h46, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step_s(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step_s(1'b1, 8'h47, 1'b1, 1'b0, 1'b0);
        check("t6_rst_q", s_q, 8'h00);

        // FWFT: head word appears without a read.
        step_f(1'b1, 8'hA5, 1'b0, 1'b0);
        check("fwft_mty",     f_mty,     1'b0);
        check("fwft_q_valid", f_q_valid, 1'b1);
        check("fwft_q_a5",    f_q,       8'hA5);
        check("fwft_amty1",   f_almost_mty, 1'b1);
        step_f(1'b1, 8'h5A, 1'b0, 1'b0);
        check("fwft_q_hold",  f_q,       8'hA5);
        check("fwft_count2",  f_count,   3'd2);
        check("fwft_amty2",   f_almost_mty, 1'b0);
        step_f(1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft_q_5a",    f_q,       8'h5A);
        check("fwft_count1",  f_count,   3'd1);
        step_f(1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft_mty_end", f_mty,     1'b1);
        check("fwft_qv_end",  f_q_valid, 1'b0);
        for (int i = 0; i < 4; i++) step_f(1'b1, 8'hC1 + 8'(i), 1'b0, 1'b0);
        check("fwft_full",    f_full,        1'b1);
        check("fwft_afull",   f_almost_full, 1'b1);
        check("fwft_q_c1",    f_q,           8'hC1);
        step_f(1'b1, 8'hDD, 1'b0, 1'b0);
        check("fwft_ovf",     f_overflow,    1'b1);
        for (int i = 0; i < 5; i++) step_f(1'b0, 8'h00, 1'b1, 1'b0);
        check("fwft_unf",     f_underflow,   1'b1);
        step_f(1'b0, 8'h00, 1'b0, 1'b1);
        check("fwft_flush_ovf", f_overflow,  1'b0);
        check("fwft_flush_unf", f_underflow, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
